gain_channel_selector: RTL and testbench
========================================

Name: gain_channel_selector

Overview:
- Control stage directly upstream of the alpha sequence generator. Drives its `select` and `enable_transition` inputs.
- Monitors the high-gain channel sample stream and decides when to crossfade between channels:
  - to the low-gain channel (alpha=0) on overload risk;
  - back to the high-gain channel (alpha=16) after sustained quiet.
- Keeps a shadow copy of the alpha count so it knows when a ramp has finished.

Parameters:
- DATA_WIDTH, 16, width of the signed high-gain sample.
- THRESH_HIGH, 24000, magnitude at or above which a sample counts as overload.
- THRESH_LOW, 4000, magnitude strictly below which a sample counts as quiet. Must be less than THRESH_HIGH.
- HOLD_SAMPLES, 4800, number of consecutive quiet valid samples required before ramping toward the high-gain channel. Must be at least 1.
- RISE_DIV, 48, number of valid samples per alpha step while ramping up (toward alpha=16). Must be at least 1.
- FALL_DIV, 1, number of valid samples per alpha step while ramping down (toward alpha=0). Must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- sample_valid  in  1  qualifies `hg_sample`; one-cycle strobe per sample.
- hg_sample  in  DATA_WIDTH  signed high-gain channel sample.
- select  out  1  0 = step toward alpha=0 (low gain), 1 = step toward alpha=16 (high gain).
- enable_transition  out  1  one-cycle step pulse to the downstream generator.
- alpha_est  out  5  shadow alpha value, range 0..16.
- busy  out  1  high while in either ramp state.

Behaviour:
- Reset (asynchronous, active-high):
  - state = AT_A;
  - select = 0, enable_transition = 0, alpha_est = 0, busy = 0;
  - quiet_cnt = 0, step_cnt = 0.
- Magnitude: mag = |hg_sample|. The most-negative input saturates to 2^(DATA_WIDTH-1)-1.
  - overload = (mag >= THRESH_HIGH).
  - quiet = (mag < THRESH_LOW).
- Nothing advances on cycles with sample_valid = 0. All decisions use only valid samples.
- quiet_cnt:
  - on a valid quiet sample: increment, saturating at HOLD_SAMPLES;
  - on a valid non-quiet sample: clear to 0;
  - always cleared on entry to AT_A and to RAMP_TO_A.
- step_cnt: cleared on entry to any ramp state. In a ramp state each valid sample increments it; when it reaches DIV-1 (RISE_DIV or FALL_DIV as applicable):
  - it wraps to 0;
  - enable_transition is registered high for exactly the next cycle;
  - alpha_est is updated on that same edge (+1 in RAMP_TO_B, -1 in RAMP_TO_A).
  - Net effect: alpha_est equals the downstream count one cycle after the pulse.
- enable_transition is never high in AT_A or AT_B. It is never high for two consecutive cycles unless sample_valid is high on consecutive cycles and DIV = 1.
- select is registered from the state: 1 in RAMP_TO_B and AT_B, 0 otherwise. It changes at the state-entry edge, so it is stable at least one cycle before the first pulse of a ramp.
- States:
  - AT_A (alpha=0): when a valid quiet sample brings quiet_cnt to HOLD_SAMPLES, go to RAMP_TO_B.
  - RAMP_TO_B:
    - a valid overload sample goes to RAMP_TO_A immediately (abort); no pulse is issued for that sample, even if step_cnt would have wrapped;
    - otherwise step as above; on the edge where alpha_est becomes 16, go to AT_B.
  - AT_B (alpha=16): a valid overload sample goes to RAMP_TO_A.
  - RAMP_TO_A:
    - step using FALL_DIV; on the edge where alpha_est becomes 0, go to AT_A;
    - overload and quiet samples do not change the state.
- busy = 1 exactly in RAMP_TO_B and RAMP_TO_A.
- Bounds: alpha_est never leaves 0..16. No pulse is generated that would drive the downstream count past its limits.
- Reset asserted mid-ramp returns everything to the reset values. The downstream generator shares the reset, so both return to 0 together.

Test Plan:
Bench parameters: DATA_WIDTH=16, THRESH_HIGH=1000, THRESH_LOW=200, HOLD_SAMPLES=4, RISE_DIV=2, FALL_DIV=1. Valid sample every 3 cycles unless stated.
- Quiet ramp-up:
  - stimulus: 4 valid samples of value 50, then continued quiet samples;
  - response: RAMP_TO_B entered after the 4th sample (select=1, busy=1); a pulse every 2nd valid sample; alpha_est reaches 16 after 32 further samples; then AT_B with busy=0 and no further pulses.
- Overload from AT_B:
  - stimulus: one valid sample of -1500;
  - response: select=0 on the next edge; a pulse on every subsequent valid sample; alpha_est reaches 0 after 16 samples; then AT_A.
- Abort mid-rise:
  - stimulus: with alpha_est=5 in RAMP_TO_B, send a sample of 1000;
  - response: RAMP_TO_A, no pulse for that sample, alpha_est counts down from 5 to 0 over 5 valid samples.
- Quiet run broken:
  - stimulus: in AT_A, send 50, 50, 50, 300, 50, 50, 50;
  - response: no transition; quiet_cnt=3 at the end; a 4th consecutive quiet sample triggers RAMP_TO_B.
- Saturation and gating:
  - stimulus: hg_sample = -32768 with sample_valid=0 for 10 cycles, then with sample_valid=1 for one sample;
  - response: no state change while invalid; then overload is detected.
- Reset mid-ramp:
  - stimulus: assert reset with alpha_est=9 in RAMP_TO_B;
  - response: outputs go to 0 asynchronously; AT_A after release.

Source files
------------

// File: rtl/gain_channel_selector_if.sv
// Sample stream into the gain channel selector and its control outputs toward
// the alpha sequence generator.
interface gain_channel_selector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] hg_sample;
    logic                         select;
    logic                         enable_transition;
    logic [4:0]                   alpha_est;
    logic                         busy;

    modport master (
        output sample_valid, hg_sample,
        input  select, enable_transition, alpha_est, busy
    );

    modport slave (
        input  sample_valid, hg_sample,
        output select, enable_transition, alpha_est, busy
    );
endinterface

// File: rtl/gain_channel_selector.sv
// Decides when to crossfade between high- and low-gain channels and drives the
// alpha generator's select/step inputs, tracking a shadow copy of alpha.
module gain_channel_selector #(
    parameter int DATA_WIDTH   = 16,
    parameter int THRESH_HIGH  = 24000,
    parameter int THRESH_LOW   = 4000,
    parameter int HOLD_SAMPLES = 4800,
    parameter int RISE_DIV     = 48,
    parameter int FALL_DIV     = 1
) (
    input logic                     clk,
    input logic                     reset,
    gain_channel_selector_if.slave  bus
);

    localparam logic [1:0] AT_A      = 2'd0;
    localparam logic [1:0] RAMP_TO_B = 2'd1;
    localparam logic [1:0] AT_B      = 2'd2;
    localparam logic [1:0] RAMP_TO_A = 2'd3;

    localparam int MAX_DIV = (RISE_DIV > FALL_DIV) ? RISE_DIV : FALL_DIV;
    localparam int SW      = $clog2(MAX_DIV + 1);
    localparam int QW      = $clog2(HOLD_SAMPLES + 1);

    localparam logic [SW-1:0]         RISE_LAST = SW'(RISE_DIV - 1);
    localparam logic [SW-1:0]         FALL_LAST = SW'(FALL_DIV - 1);
    localparam logic [QW-1:0]         HOLD_Q    = QW'(HOLD_SAMPLES);
    localparam logic [DATA_WIDTH-1:0] TH_HI     = DATA_WIDTH'(THRESH_HIGH);
    localparam logic [DATA_WIDTH-1:0] TH_LO     = DATA_WIDTH'(THRESH_LOW);

    // |x| with the most-negative code clamped to the largest positive value.
    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic signed [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] ux;
        ux = $unsigned(x);
        if (ux == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (x[DATA_WIDTH-1])
            return (~ux) + DATA_WIDTH'(1);
        else
            return ux;
    endfunction

    logic signed [DATA_WIDTH-1:0] sample;
    logic [DATA_WIDTH-1:0]        mag;
    logic                         overload;
    logic                         quiet;
    logic [QW-1:0]                quiet_nxt;

    logic [1:0]    state_p0;
    logic          select_p0;
    logic          en_p0;
    logic [4:0]    alpha_p0;
    logic [QW-1:0] quiet_cnt_p0;
    logic [SW-1:0] step_cnt_p0;

    assign sample = bus.hg_sample;

    always_comb begin
        mag       = sat_abs(sample);
        overload  = (mag >= TH_HI);
        quiet     = (mag < TH_LO);
        quiet_nxt = '0;
        if (quiet)
            quiet_nxt = (quiet_cnt_p0 == HOLD_Q) ? HOLD_Q : quiet_cnt_p0 + QW'(1);
    end

    // p0: decision and shadow-alpha register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0     <= AT_A;
            select_p0    <= 1'b0;
            en_p0        <= 1'b0;
            alpha_p0     <= 5'd0;
            quiet_cnt_p0 <= '0;
            step_cnt_p0  <= '0;
        end else begin
            en_p0 <= 1'b0;
            if (bus.sample_valid) begin
                quiet_cnt_p0 <= quiet_nxt;
                case (state_p0)
                    AT_A: begin
                        if (quiet_nxt == HOLD_Q) begin
                            state_p0    <= RAMP_TO_B;
                            select_p0   <= 1'b1;
                            step_cnt_p0 <= '0;
                        end
                    end
                    RAMP_TO_B: begin
                        // An overload abort swallows this sample's step, even on a wrap.
                        if (overload) begin
                            state_p0     <= RAMP_TO_A;
                            select_p0    <= 1'b0;
                            step_cnt_p0  <= '0;
                            quiet_cnt_p0 <= '0;
                        end else if (step_cnt_p0 == RISE_LAST) begin
                            step_cnt_p0 <= '0;
                            en_p0       <= 1'b1;
                            alpha_p0    <= alpha_p0 + 5'd1;
                            if (alpha_p0 == 5'd15)
                                state_p0 <= AT_B;
                        end else begin
                            step_cnt_p0 <= step_cnt_p0 + SW'(1);
                        end
                    end
                    AT_B: begin
                        if (overload) begin
                            state_p0     <= RAMP_TO_A;
                            select_p0    <= 1'b0;
                            step_cnt_p0  <= '0;
                            quiet_cnt_p0 <= '0;
                        end
                    end
                    RAMP_TO_A: begin
                        // An abort before the first rise step leaves nothing to undo.
                        if (alpha_p0 == 5'd0) begin
                            state_p0     <= AT_A;
                            quiet_cnt_p0 <= '0;
                        end else if (step_cnt_p0 == FALL_LAST) begin
                            step_cnt_p0 <= '0;
                            en_p0       <= 1'b1;
                            alpha_p0    <= alpha_p0 - 5'd1;
                            if (alpha_p0 == 5'd1) begin
                                state_p0     <= AT_A;
                                quiet_cnt_p0 <= '0;
                            end
                        end else begin
                            step_cnt_p0 <= step_cnt_p0 + SW'(1);
                        end
                    end
                    default: begin
                        state_p0  <= AT_A;
                        select_p0 <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.select            = select_p0;
    assign bus.enable_transition = en_p0;
    assign bus.alpha_est         = alpha_p0;
    assign bus.busy              = (state_p0 == RAMP_TO_B) || (state_p0 == RAMP_TO_A);

endmodule

// File: tb/tb_gain_channel_selector.sv
// Bench for gain_channel_selector: per-cycle scoreboard against a behavioural
// model plus end-of-phase checks against hand-derived constants.
module tb_gain_channel_selector;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gain_channel_selector_if #(.DATA_WIDTH(DW)) bus ();

    gain_channel_selector #(
        .DATA_WIDTH(DW), .THRESH_HIGH(1000), .THRESH_LOW(200),
        .HOLD_SAMPLES(4), .RISE_DIV(2), .FALL_DIV(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic       sel;
        logic       en;
        logic [4:0] alpha;
        logic       busy;
    } outs_t;

    typedef struct {
        logic v;
        int   value;
        int   n;
        logic sel;
        logic busy;
        int   alpha;
    } vec_t;

    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Behavioural reference: 0=AT_A 1=RAMP_TO_B 2=AT_B 3=RAMP_TO_A
    int   m_state, m_alpha, m_quiet, m_step;
    logic m_en;

    function automatic void model_reset();
        m_state = 0; m_alpha = 0; m_quiet = 0; m_step = 0; m_en = 1'b0;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.sel   = (m_state == 1 || m_state == 2);
        o.en    = m_en;
        o.alpha = 5'(m_alpha);
        o.busy  = (m_state == 1 || m_state == 3);
        return o;
    endfunction

    function automatic void model_step(logic v, int s);
        int  mag;
        logic ov, qt;
        m_en = 1'b0;
        if (!v) return;
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        ov = (mag >= 1000);
        qt = (mag < 200);
        m_quiet = qt ? ((m_quiet < 4) ? m_quiet + 1 : 4) : 0;
        case (m_state)
            0: if (m_quiet == 4) begin m_state = 1; m_step = 0; end
            1: begin
                if (ov) begin
                    m_state = 3; m_step = 0; m_quiet = 0;
                end else begin
                    m_step++;
                    if (m_step == 2) begin
                        m_step = 0; m_en = 1'b1; m_alpha++;
                        if (m_alpha == 16) m_state = 2;
                    end
                end
            end
            2: if (ov) begin m_state = 3; m_step = 0; m_quiet = 0; end
            default: begin
                if (m_alpha == 0) begin
                    m_state = 0; m_quiet = 0;
                end else begin
                    m_step = 0; m_en = 1'b1; m_alpha--;
                    if (m_alpha == 0) begin m_state = 0; m_quiet = 0; end
                end
            end
        endcase
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.sel   = bus.select;
        o.en    = bus.enable_transition;
        o.alpha = bus.alpha_est;
        o.busy  = bus.busy;
        return o;
    endfunction

    task automatic check(string name, outs_t act, outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got sel=%0b en=%0b alpha=%0d busy=%0b, expected sel=%0b en=%0b alpha=%0d busy=%0b",
                     name, act.sel, act.en, act.alpha, act.busy, exp.sel, exp.en, exp.alpha, exp.busy);
        end
    endtask

    task automatic phase_check(string name, logic sel, logic busy, int alpha);
        checks++;
        if (bus.select !== sel || bus.busy !== busy || bus.alpha_est !== 5'(alpha)) begin
            errors++;
            $display("FAIL %s: got sel=%0b busy=%0b alpha=%0d, expected sel=%0b busy=%0b alpha=%0d",
                     name, bus.select, bus.busy, bus.alpha_est, sel, busy, alpha);
        end
    endtask

    task automatic cycle(logic v, int s);
        outs_t e;
        bus.sample_valid = v;
        bus.hg_sample    = DW'(s);
        model_step(v, s);
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", dut_outs(), e);
    endtask

    task automatic send(logic v, int s);
        cycle(v, s);
        cycle(1'b0, s);
        cycle(1'b0, s);
    endtask

    vec_t vt[22];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1,     50,  3, 1'b0, 1'b0,  0};
        vt[1]  = '{1'b1,     50,  1, 1'b1, 1'b1,  0};
        vt[2]  = '{1'b1,     50, 32, 1'b1, 1'b0, 16};
        vt[3]  = '{1'b1,     50,  4, 1'b1, 1'b0, 16};
        vt[4]  = '{1'b1,  -1500,  1, 1'b0, 1'b1, 16};
        vt[5]  = '{1'b1,     50, 16, 1'b0, 1'b0,  0};
        vt[6]  = '{1'b1,     50,  3, 1'b0, 1'b0,  0};
        vt[7]  = '{1'b1,    300,  1, 1'b0, 1'b0,  0};
        vt[8]  = '{1'b1,     50,  3, 1'b0, 1'b0,  0};
        vt[9]  = '{1'b1,     50,  1, 1'b1, 1'b1,  0};
        vt[10] = '{1'b1,     50, 10, 1'b1, 1'b1,  5};
        vt[11] = '{1'b1,     50,  1, 1'b1, 1'b1,  5};
        vt[12] = '{1'b1,   1000,  1, 1'b0, 1'b1,  5};
        vt[13] = '{1'b1,     50,  4, 1'b0, 1'b1,  1};
        vt[14] = '{1'b1,     50,  1, 1'b0, 1'b0,  0};
        vt[15] = '{1'b1,     50,  4, 1'b1, 1'b1,  0};
        vt[16] = '{1'b1,     50, 32, 1'b1, 1'b0, 16};
        vt[17] = '{1'b0, -32768, 10, 1'b1, 1'b0, 16};
        vt[18] = '{1'b1, -32768,  1, 1'b0, 1'b1, 16};
        vt[19] = '{1'b1,     50, 16, 1'b0, 1'b0,  0};
        vt[20] = '{1'b1,     50,  4, 1'b1, 1'b1,  0};
        vt[21] = '{1'b1,     50, 18, 1'b1, 1'b1,  9};

        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.hg_sample    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_outs(), '0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            for (int k = 0; k < vt[i].n; k++)
                send(vt[i].v, vt[i].value);
            phase_check($sformatf("phase%0d", i), vt[i].sel, vt[i].busy, vt[i].alpha);
        end

        // Asynchronous reset in the middle of a cycle while ramping at alpha=9.
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", dut_outs(), '0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", dut_outs(), '0);
        reset = 1'b0;

        for (int k = 0; k < 3; k++)
            send(1'b1, 50);
        phase_check("post_reset_quiet3", 1'b0, 1'b0, 0);
        send(1'b1, 50);
        phase_check("post_reset_ramp", 1'b1, 1'b1, 0);
        send(1'b1, 50);
        send(1'b1, 50);
        phase_check("post_reset_step", 1'b1, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
